perf_report_sequencer: RTL and testbench

PERF_REPORT_SEQUENCER -- requirements
Module: perf_report_sequencer

---
 rtl/perf_report_sequencer.sv | 146 ++++++++++++++
 tb/tb_perf_report_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_report_sequencer.sv
`default_nettype none
// ============================================================================
// perf_report_sequencer : periodically snapshots six 8-bit counters and sends
// them as an 8-byte UART frame (header, six values, XOR checksum).
// Revision 1.0
// ============================================================================
module perf_report_sequencer #(
    parameter int         PERIOD = 60000,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable_i,
    input  logic [7:0] val0_i,
    input  logic [7:0] val1_i,
    input  logic [7:0] val2_i,
    input  logic [7:0] val3_i,
    input  logic [7:0] val4_i,
    input  logic [7:0] val5_i,
    output logic       snap_o,
    input  logic       tx_busy_i,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    output logic       frame_busy_o,
    output logic       overrun_o
);

    localparam int            c_cw   = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SNAP      = 3'd1,
        S_CAPTURE   = 3'd2,
        S_LOAD      = 3'd3,
        S_START     = 3'd4,
        S_WAIT_ACK  = 3'd5,
        S_WAIT_DONE = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [c_cw-1:0] r_cnt;
    logic            w_tick;
    logic [2:0]      r_idx;
    logic [7:0]      r_val [6];
    logic [7:0]      r_chk;
    logic [7:0]      r_tx_data;
    logic            r_overrun;
    logic [7:0]      w_byte;

    assign w_tick = enable_i && (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (!rstn || !enable_i) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        snap_o     = 1'b0;
        tx_start_o = 1'b0;
        case (r_state)
            S_IDLE:      if (w_tick) w_next = S_SNAP;
            S_SNAP: begin
                snap_o = 1'b1;
                w_next = S_CAPTURE;
            end
            S_CAPTURE:   w_next = S_LOAD;
            S_LOAD:      w_next = S_START;
            S_START: begin
                // Start is gated combinationally by busy so it can never overlap a byte.
                if (!tx_busy_i) begin
                    tx_start_o = 1'b1;
                    w_next     = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK:  if (tx_busy_i) w_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    w_next = (r_idx == 3'd7) ? S_IDLE : S_LOAD;
                end
            end
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_idx)
            3'd0:    w_byte = HEADER;
            3'd7:    w_byte = r_chk;
            default: w_byte = r_val[r_idx - 3'd1];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_idx     <= 3'd0;
            r_chk     <= 8'h00;
            r_tx_data <= 8'h00;
            r_overrun <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                r_val[i] <= 8'h00;
            end
        end else begin
            // Any tick that cannot open a frame is lost, including one coinciding with the last byte.
            if (w_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_CAPTURE: begin
                    r_val[0] <= val0_i;
                    r_val[1] <= val1_i;
                    r_val[2] <= val2_i;
                    r_val[3] <= val3_i;
                    r_val[4] <= val4_i;
                    r_val[5] <= val5_i;
                    r_chk    <= val0_i ^ val1_i ^ val2_i ^ val3_i ^ val4_i ^ val5_i;
                    r_idx    <= 3'd0;
                end
                S_LOAD:      r_tx_data <= w_byte;
                S_WAIT_DONE: if (!tx_busy_i && (r_idx != 3'd7)) r_idx <= r_idx + 3'd1;
                default:     ;
            endcase
        end
    end

    assign tx_data_o    = r_tx_data;
    assign frame_busy_o = (r_state != S_IDLE);
    assign overrun_o    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_perf_report_sequencer.sv
`default_nettype none
// ============================================================================
// tb_perf_report_sequencer : directed bench with a UART busy model and monitor.
// Revision 1.0
// ============================================================================
module tb_perf_report_sequencer;

    localparam int         c_period = 20;
    localparam logic [7:0] c_header = 8'hA5;

    logic       clk = 1'b0;
    logic       rstn, enable_i, ext_busy;
    logic       tx_busy_i, snap_o, tx_start_o, frame_busy_o, overrun_o;
    logic [7:0] val0_i, val1_i, val2_i, val3_i, val4_i, val5_i, tx_data_o;

    int checks = 0;
    int errors = 0;

    int         hold_len     = 10;
    int         bcnt         = 0;
    int         snap_cnt     = 0;
    int         start_cnt    = 0;
    int         viol_cnt     = 0;
    int         unstable_cnt = 0;
    logic       tracking     = 1'b0;
    logic [7:0] held         = 8'h00;
    logic [7:0] txq [$];
    logic [7:0] exp_b [8];

    perf_report_sequencer #(.PERIOD(c_period), .HEADER(c_header)) dut (
        .clk(clk), .rstn(rstn), .enable_i(enable_i),
        .val0_i(val0_i), .val1_i(val1_i), .val2_i(val2_i),
        .val3_i(val3_i), .val4_i(val4_i), .val5_i(val5_i),
        .snap_o(snap_o), .tx_busy_i(tx_busy_i), .tx_start_o(tx_start_o),
        .tx_data_o(tx_data_o), .frame_busy_o(frame_busy_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    assign tx_busy_i = ext_busy | (bcnt > 0);

    // UART model: busy rises the cycle after a start and lasts hold_len cycles.
    always @(posedge clk) begin
        if (tx_start_o) begin
            bcnt      <= hold_len;
            txq.push_back(tx_data_o);
            start_cnt <= start_cnt + 1;
            held      <= tx_data_o;
            tracking  <= 1'b1;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
        end
        if (tx_start_o && tx_busy_i) viol_cnt <= viol_cnt + 1;
        if (snap_o) snap_cnt <= snap_cnt + 1;
        if (tracking && tx_busy_i && (tx_data_o !== held)) unstable_cnt <= unstable_cnt + 1;
        if (!frame_busy_o) tracking <= 1'b0;
    end

    task automatic set_vals(input logic [7:0] a, b, c, d, e, f);
        val0_i = a; val1_i = b; val2_i = c; val3_i = d; val4_i = e; val5_i = f;
    endtask

    task automatic set_exp(input logic [7:0] a, b, c, d, e, f, k);
        exp_b[0] = c_header; exp_b[1] = a; exp_b[2] = b; exp_b[3] = c;
        exp_b[4] = d; exp_b[5] = e; exp_b[6] = f; exp_b[7] = k;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        enable_i = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_snap(input int limit, output int n);
        n = 0;
        while (snap_o !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int n = 0;
        while (frame_busy_o !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (frame_busy_o === 1'b0);
    endtask

    task automatic wait_bytes(input int base, input int cnt, input int limit, output bit ok);
        int n = 0;
        while ((txq.size() - base) < cnt && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = ((txq.size() - base) >= cnt);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (snap_o !== 1'b0) begin errors++; $display("FAIL reset_snap: got %b expected 0", snap_o); end
        checks++; if (tx_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", tx_start_o); end
        checks++; if (tx_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", tx_data_o); end
        checks++; if (frame_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", frame_busy_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun_o); end
    endtask

    task automatic test_first_frame();
        int base, sc, early;
        bit ok;
        do_reset();
        set_vals(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20);
        set_exp(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h3F);
        enable_i = 1'b1;
        base = txq.size();
        sc = start_cnt;
        early = 0;
        for (int i = 1; i < c_period; i++) begin
            @(negedge clk);
            if (snap_o !== 1'b0 || frame_busy_o !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL tick_early: got %0d early cycles expected 0", early); end
        @(negedge clk);
        checks++; if (snap_o !== 1'b1) begin errors++; $display("FAIL tick_snap: got %b expected 1 at cycle 20", snap_o); end
        checks++; if (frame_busy_o !== 1'b1) begin errors++; $display("FAIL tick_busy: got %b expected 1", frame_busy_o); end
        enable_i = 1'b0;
        @(negedge clk);
        checks++; if (snap_o !== 1'b0) begin errors++; $display("FAIL snap_width: got %b expected 0", snap_o); end
        wait_idle(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame1_timeout: got busy %b expected 0", frame_busy_o); end
        checks++; if (start_cnt - sc !== 8) begin errors++; $display("FAIL frame1_starts: got %0d expected 8", start_cnt - sc); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (txq.size() <= base + i || txq[base + i] !== exp_b[i]) begin
                errors++;
                $display("FAIL frame1_byte%0d: got %h expected %h", i,
                         (txq.size() > base + i) ? txq[base + i] : 8'hxx, exp_b[i]);
            end
        end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL frame1_overrun: got %b expected 0", overrun_o); end
    endtask

    task automatic test_latched_values();
        int base, n;
        bit ok;
        do_reset();
        set_vals(8'h3C, 8'hFF, 8'h00, 8'h81, 8'h5A, 8'hC3);
        set_exp(8'h3C, 8'hFF, 8'h00, 8'h81, 8'h5A, 8'hC3, 8'hDB);
        enable_i = 1'b1;
        base = txq.size();
        wait_snap(100, n);
        enable_i = 1'b0;
        repeat (2) @(negedge clk);
        set_vals(8'(~8'h3C), 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        wait_idle(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL latch_timeout: got busy %b expected 0", frame_busy_o); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (txq.size() <= base + i || txq[base + i] !== exp_b[i]) begin
                errors++;
                $display("FAIL latch_byte%0d: got %h expected %h", i,
                         (txq.size() > base + i) ? txq[base + i] : 8'hxx, exp_b[i]);
            end
        end
    endtask

    task automatic test_busy_at_start();
        int sc, uc, n;
        bit ok;
        do_reset();
        set_vals(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20);
        ext_busy = 1'b1;
        enable_i = 1'b1;
        wait_snap(100, n);
        enable_i = 1'b0;
        sc = start_cnt;
        uc = unstable_cnt;
        repeat (15) @(negedge clk);
        checks++; if (start_cnt !== sc || tx_start_o !== 1'b0) begin errors++; $display("FAIL busy_withheld: got %0d starts expected 0", start_cnt - sc); end
        ext_busy = 1'b0;
        #1;
        checks++; if (tx_start_o !== 1'b1) begin errors++; $display("FAIL busy_release_start: got %b expected 1", tx_start_o); end
        checks++; if (tx_data_o !== c_header) begin errors++; $display("FAIL busy_release_data: got %h expected %h", tx_data_o, c_header); end
        @(negedge clk);
        checks++; if (tx_start_o !== 1'b0 || start_cnt - sc !== 1) begin errors++; $display("FAIL busy_single_start: got %0d starts expected 1", start_cnt - sc); end
        wait_idle(400, ok);
        checks++; if (!ok || start_cnt - sc !== 8) begin errors++; $display("FAIL busy_frame_starts: got %0d expected 8", start_cnt - sc); end
        checks++; if (unstable_cnt !== uc) begin errors++; $display("FAIL busy_data_stable: got %0d changes expected 0", unstable_cnt - uc); end
    endtask

    task automatic test_overrun();
        int base, ss, n;
        bit ok;
        do_reset();
        hold_len = 16;
        set_vals(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20);
        set_exp(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h3F);
        enable_i = 1'b1;
        base = txq.size();
        ss = snap_cnt;
        wait_snap(100, n);
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_initial: got %b expected 0", overrun_o); end
        repeat (25) @(negedge clk);
        enable_i = 1'b0;
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun_o); end
        wait_idle(600, ok);
        checks++; if (!ok || snap_cnt - ss !== 1) begin errors++; $display("FAIL ovr_snaps: got %0d expected 1", snap_cnt - ss); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (txq.size() <= base + i || txq[base + i] !== exp_b[i]) begin
                errors++;
                $display("FAIL ovr_byte%0d: got %h expected %h", i,
                         (txq.size() > base + i) ? txq[base + i] : 8'hxx, exp_b[i]);
            end
        end
        repeat (30) @(negedge clk);
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun_o); end
        hold_len = 10;
    endtask

    task automatic test_reset_mid_frame();
        int base, n;
        bit ok;
        do_reset();
        set_vals(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20);
        enable_i = 1'b1;
        wait_snap(100, n);
        enable_i = 1'b0;
        base = txq.size();
        wait_bytes(base, 4, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_byte3: got %0d bytes expected 4", txq.size() - base); end
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (snap_o !== 1'b0 || tx_start_o !== 1'b0) begin errors++; $display("FAIL rmid_pulses: got snap %b start %b expected 0 0", snap_o, tx_start_o); end
        checks++; if (tx_data_o !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h expected 00", tx_data_o); end
        checks++; if (frame_busy_o !== 1'b0 || overrun_o !== 1'b0) begin errors++; $display("FAIL rmid_flags: got busy %b ovr %b expected 0 0", frame_busy_o, overrun_o); end
        rstn = 1'b1;
        enable_i = 1'b1;
        base = txq.size();
        wait_snap(100, n);
        enable_i = 1'b0;
        checks++; if (n !== c_period) begin errors++; $display("FAIL rmid_tick_delay: got %0d expected %0d", n, c_period); end
        wait_idle(400, ok);
        checks++; if (!ok || txq.size() - base !== 8) begin errors++; $display("FAIL rmid_restart_len: got %0d expected 8", txq.size() - base); end
        checks++; if (txq.size() <= base || txq[base] !== c_header) begin errors++; $display("FAIL rmid_restart_hdr: got %h expected %h", (txq.size() > base) ? txq[base] : 8'hxx, c_header); end
    endtask

    task automatic test_enable_drop();
        int base, ss, busy_seen, n;
        bit ok;
        do_reset();
        set_vals(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20);
        enable_i = 1'b1;
        wait_snap(100, n);
        base = txq.size();
        wait_bytes(base, 3, 300, ok);
        enable_i = 1'b0;
        wait_idle(400, ok);
        checks++; if (!ok || txq.size() - base !== 8) begin errors++; $display("FAIL edrop_len: got %0d expected 8", txq.size() - base); end
        checks++; if (txq.size() < base + 8 || txq[base + 7] !== 8'h3F) begin errors++; $display("FAIL edrop_last: got %h expected 3F", (txq.size() >= base + 8) ? txq[base + 7] : 8'hxx); end
        ss = snap_cnt;
        busy_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (frame_busy_o !== 1'b0) busy_seen++;
        end
        checks++; if (snap_cnt !== ss || busy_seen !== 0) begin errors++; $display("FAIL edrop_quiet: got %0d snaps %0d busy expected 0 0", snap_cnt - ss, busy_seen); end
    endtask

    initial begin
        rstn = 1'b0;
        enable_i = 1'b0;
        ext_busy = 1'b0;
        set_vals(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        test_reset();
        test_first_frame();
        test_latched_values();
        test_busy_at_start();
        test_overrun();
        test_reset_mid_frame();
        test_enable_drop();
        checks++; if (viol_cnt !== 0) begin errors++; $display("FAIL start_while_busy: got %0d expected 0", viol_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
